fetch_stage: RTL and testbench

//  Instruction-fetch stage of the 5-stage RV32I pipeline: owns the PC register and the IF/ID pipeline register.

---
 rtl/fetch_stage.sv | 112 +++++++++++
 tb/tb_fetch_stage.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register and a one-word
// return buffer for a variable-latency instruction memory (req/ready handshake).
module fetch_stage #(
  parameter int               XLEN      = 32,
  parameter logic [XLEN-1:0]  RESET_PC  = '0,
  parameter logic [31:0]      NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pc_WriteEnable,
  input  logic            if_id_WriteEnable,
  input  logic            flush,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] IF_ID_pc,
  output logic [31:0]     IF_ID_instr,
  output logic            IF_ID_valid,
  output logic [31:0]     stall_cycles
);
  typedef enum logic [1:0] {FETCH, HOLD, DROP} state_t;

  state_t          state, state_nx;
  logic [XLEN-1:0] pc, pc_nx, if_id_pc_nx;
  logic [31:0]     instr_nx, buffer, buffer_nx;
  logic            valid_nx;
  logic            advance;

  // A split enable pair counts as a stall: never advance one side alone.
  assign advance   = pc_WriteEnable & if_id_WriteEnable;
  assign imem_req  = (state != HOLD);
  assign imem_addr = pc;

  always_comb begin
    state_nx    = state;
    pc_nx       = pc;
    if_id_pc_nx = IF_ID_pc;
    instr_nx    = IF_ID_instr;
    valid_nx    = IF_ID_valid;
    buffer_nx   = buffer;
    if (flush) begin
      pc_nx       = redirect_pc & ~XLEN'(3);
      if_id_pc_nx = '0;
      instr_nx    = NOP_INSTR;
      valid_nx    = 1'b0;
      buffer_nx   = '0;
      // An unanswered request must be waited out so its word is not mistaken for the target.
      state_nx    = (state == HOLD || imem_ready) ? FETCH : DROP;
    end else begin
      case (state)
        FETCH: begin
          if (imem_ready) begin
            if (advance) begin
              if_id_pc_nx = pc;
              instr_nx    = imem_rdata;
              valid_nx    = 1'b1;
              pc_nx       = pc + XLEN'(4);
            end else begin
              buffer_nx = imem_rdata;
              state_nx  = HOLD;
            end
          end else if (if_id_WriteEnable) begin
            if_id_pc_nx = pc;
            instr_nx    = NOP_INSTR;
            valid_nx    = 1'b0;
          end
        end
        HOLD: begin
          if (advance) begin
            if_id_pc_nx = pc;
            instr_nx    = buffer;
            valid_nx    = 1'b1;
            pc_nx       = pc + XLEN'(4);
            state_nx    = FETCH;
          end
        end
        DROP: begin
          if (imem_ready) state_nx = FETCH;
          if (if_id_WriteEnable) begin
            if_id_pc_nx = pc;
            instr_nx    = NOP_INSTR;
            valid_nx    = 1'b0;
          end
        end
        default: state_nx = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= FETCH;
      pc           <= RESET_PC;
      IF_ID_pc     <= '0;
      IF_ID_instr  <= NOP_INSTR;
      IF_ID_valid  <= 1'b0;
      buffer       <= '0;
      stall_cycles <= '0;
    end else begin
      state       <= state_nx;
      pc          <= pc_nx;
      IF_ID_pc    <= if_id_pc_nx;
      IF_ID_instr <= instr_nx;
      IF_ID_valid <= valid_nx;
      buffer      <= buffer_nx;
      if (!pc_WriteEnable && stall_cycles != 32'hFFFF_FFFF)
        stall_cycles <= stall_cycles + 32'd1;
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: imem returns addr^KEY so every word identifies its PC.
module tb_fetch_stage;
  localparam logic [31:0] KEY = 32'h5A5A_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset, pc_we, if_id_we, flush, ready;
  logic [31:0] redirect_pc, imem_addr, imem_rdata, if_id_pc, if_id_instr, stall_cycles;
  logic        imem_req, if_id_valid;
  logic        ovr;
  logic [31:0] ovr_val;
  int          checks = 0, failures = 0;

  always #5 clk = ~clk;

  assign imem_rdata = ovr ? ovr_val : (imem_addr ^ KEY);

  fetch_stage dut (
    .clk(clk), .reset(reset), .pc_WriteEnable(pc_we), .if_id_WriteEnable(if_id_we),
    .flush(flush), .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(ready), .imem_rdata(imem_rdata), .IF_ID_pc(if_id_pc),
    .IF_ID_instr(if_id_instr), .IF_ID_valid(if_id_valid), .stall_cycles(stall_cycles)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1; pc_we = 1; if_id_we = 1; flush = 0; ready = 1; redirect_pc = '0;
    ovr = 0; ovr_val = '0;
    tick(); tick();
    reset = 0;
    checks++; if (if_id_pc !== 32'h0) begin failures++; $display("FAIL reset_pc got %h want %h", if_id_pc, 32'h0); end
    checks++; if (if_id_instr !== NOP) begin failures++; $display("FAIL reset_instr got %h want %h", if_id_instr, NOP); end
    checks++; if (if_id_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %b want 0", if_id_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL reset_req got %b/%h want 1/0", imem_req, imem_addr); end
    checks++; if (stall_cycles !== 32'd0) begin failures++; $display("FAIL reset_stall got %0d want 0", stall_cycles); end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (if_id_pc !== 32'(4*i) || if_id_instr !== (32'(4*i) ^ KEY) || if_id_valid !== 1'b1) begin
        failures++; $display("FAIL stream_%0d got %h/%h/%b want %h/%h/1", i, if_id_pc, if_id_instr, if_id_valid, 32'(4*i), 32'(4*i) ^ KEY);
      end
    end
    checks++; if (imem_addr !== 32'h8) begin failures++; $display("FAIL stream_addr got %h want 8", imem_addr); end
  endtask

  task automatic test_stall_hold();
    pc_we = 0; if_id_we = 0;
    tick();
    checks++; if (if_id_pc !== 32'h4 || imem_req !== 1'b0 || imem_addr !== 32'h8) begin
      failures++; $display("FAIL hold_enter got %h/%b/%h want 4/0/8", if_id_pc, imem_req, imem_addr);
    end
    tick();
    checks++; if (if_id_pc !== 32'h4 || if_id_valid !== 1'b1) begin failures++; $display("FAIL hold_keep got %h/%b want 4/1", if_id_pc, if_id_valid); end
    pc_we = 1; if_id_we = 1;
    tick();
    checks++; if (if_id_pc !== 32'h8 || if_id_instr !== (32'h8 ^ KEY) || imem_addr !== 32'hC || imem_req !== 1'b1) begin
      failures++; $display("FAIL hold_release got %h/%h/%h/%b want 8/%h/c/1", if_id_pc, if_id_instr, imem_addr, imem_req, 32'h8 ^ KEY);
    end
    tick();
    checks++; if (if_id_pc !== 32'hC || if_id_instr !== (32'hC ^ KEY)) begin failures++; $display("FAIL hold_next got %h/%h want c/%h", if_id_pc, if_id_instr, 32'hC ^ KEY); end
    checks++; if (stall_cycles !== 32'd2) begin failures++; $display("FAIL hold_stalls got %0d want 2", stall_cycles); end
  endtask

  task automatic test_flush_in_hold();
    pc_we = 0; if_id_we = 0;
    tick();
    flush = 1; redirect_pc = 32'h0000_0103;
    tick();
    flush = 0; pc_we = 1; if_id_we = 1;
    checks++; if (if_id_valid !== 1'b0 || if_id_instr !== NOP || if_id_pc !== 32'h0) begin
      failures++; $display("FAIL flush_bubble got %h/%h/%b want 0/13/0", if_id_pc, if_id_instr, if_id_valid);
    end
    checks++; if (imem_addr !== 32'h100 || imem_req !== 1'b1) begin failures++; $display("FAIL flush_addr got %h/%b want 100/1", imem_addr, imem_req); end
    tick();
    checks++; if (if_id_pc !== 32'h100 || if_id_instr !== (32'h100 ^ KEY) || if_id_valid !== 1'b1) begin
      failures++; $display("FAIL flush_target got %h/%h/%b want 100/%h/1", if_id_pc, if_id_instr, if_id_valid, 32'h100 ^ KEY);
    end
    checks++; if (stall_cycles !== 32'd4) begin failures++; $display("FAIL flush_stalls got %0d want 4", stall_cycles); end
  endtask

  task automatic test_drop();
    ready = 0;
    tick(); tick(); tick();
    checks++; if (if_id_pc !== 32'h104 || if_id_instr !== NOP || if_id_valid !== 1'b0 || imem_addr !== 32'h104) begin
      failures++; $display("FAIL wait_bubble got %h/%h/%b/%h want 104/13/0/104", if_id_pc, if_id_instr, if_id_valid, imem_addr);
    end
    flush = 1; redirect_pc = 32'h0000_0200;
    tick();
    flush = 0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin failures++; $display("FAIL drop_req got %b/%h want 1/200", imem_req, imem_addr); end
    ready = 1; ovr = 1; ovr_val = 32'hDEAD_BEEF;
    tick();
    ovr = 0;
    checks++; if (if_id_valid !== 1'b0 || if_id_instr !== NOP || imem_addr !== 32'h200) begin
      failures++; $display("FAIL drop_discard got %h/%b/%h want 13/0/200", if_id_instr, if_id_valid, imem_addr);
    end
    tick();
    checks++; if (if_id_pc !== 32'h200 || if_id_instr !== (32'h200 ^ KEY) || if_id_valid !== 1'b1) begin
      failures++; $display("FAIL drop_refetch got %h/%h/%b want 200/%h/1", if_id_pc, if_id_instr, if_id_valid, 32'h200 ^ KEY);
    end
  endtask

  task automatic test_wrap();
    flush = 1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    flush = 0;
    checks++; if (imem_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_start got %h want fffffffc", imem_addr); end
    tick();
    checks++; if (if_id_pc !== 32'hFFFF_FFFC || imem_addr !== 32'h0) begin
      failures++; $display("FAIL wrap got %h/%h want fffffffc/0", if_id_pc, imem_addr);
    end
  endtask

  task automatic test_reset_in_hold();
    pc_we = 0; if_id_we = 0;
    tick();
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_hold_setup got %b want 0", imem_req); end
    flush = 1; redirect_pc = 32'h0000_0400; reset = 1;
    tick();
    flush = 0; reset = 0;
    checks++; if (if_id_pc !== 32'h0 || if_id_instr !== NOP || if_id_valid !== 1'b0 || stall_cycles !== 32'd0) begin
      failures++; $display("FAIL rst_hold_regs got %h/%h/%b/%0d want 0/13/0/0", if_id_pc, if_id_instr, if_id_valid, stall_cycles);
    end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL rst_hold_state got %b/%h want 1/0", imem_req, imem_addr); end
    tick(); tick(); tick();
    checks++; if (stall_cycles !== 32'd3 || imem_addr !== 32'h0) begin
      failures++; $display("FAIL rst_stall_count got %0d/%h want 3/0", stall_cycles, imem_addr);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall_hold();
    test_flush_in_hold();
    test_drop();
    test_wrap();
    test_reset_in_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
